// File: rtl/idu_decode_stage_pkg.sv
// Shared decode definitions: immediate classes, opcode constants and the
// packet record carried through the decode skid buffer.
package idu_decode_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;
    localparam logic [2:0] EXT_R = 3'b111;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] imm;
        logic [2:0]      extop;
        logic            illegal;
    } pkt_t;

    localparam pkt_t PKT_RESET = '{pc: '0, inst: '0, imm: '0, extop: EXT_R, illegal: 1'b0};

endpackage

// File: rtl/idu_opclass.sv
// Opcode classifier: maps the 7-bit major opcode to an immediate class and
// flags anything outside the supported set as illegal.
module idu_opclass
    import idu_decode_stage_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] extop_o,
    output logic       illegal_o
);

    always_comb begin
        extop_o   = EXT_R;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: extop_o = EXT_I;
            OP_LUI, OP_AUIPC:                    extop_o = EXT_U;
            OP_STORE:                            extop_o = EXT_S;
            OP_BRANCH:                           extop_o = EXT_B;
            OP_JAL:                              extop_o = EXT_J;
            OP_REG:                              extop_o = EXT_R;
            default:                             illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// Sign-extended immediate generator selected by the immediate class.
// R-type and illegal encodings share EXT_R and produce zero.
module imm_gen
    import idu_decode_stage_pkg::*;
(
    input  logic [31:7]     inst_i,
    input  logic [2:0]      extop_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (extop_i)
            EXT_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            EXT_U: imm_o = {inst_i[31:12], 12'b0};
            EXT_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            EXT_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            EXT_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/idu_decode_stage.sv
// Decode stage: classifies and extends the incoming instruction in the same
// cycle, then holds up to two decoded packets so inst_ready is a plain flop.
module idu_decode_stage
    import idu_decode_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_extop,
    output logic            out_illegal
);

    occ_state_e      state_q, state_d;
    logic            ready_q, ready_d;
    pkt_t            head_q, head_d;
    pkt_t            skid_q, skid_d;
    pkt_t            pkt_in;
    logic [2:0]      dec_extop;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic            push, pop;

    idu_opclass u_opclass (
        .opcode_i  (in_inst[6:0]),
        .extop_o   (dec_extop),
        .illegal_o (dec_illegal)
    );

    imm_gen u_imm_gen (
        .inst_i  (in_inst[31:7]),
        .extop_i (dec_extop),
        .imm_o   (dec_imm)
    );

    assign pkt_in = '{pc: in_pc, inst: in_inst, imm: dec_imm, extop: dec_extop, illegal: dec_illegal};

    assign out_valid = (state_q != ST_EMPTY);
    assign push      = inst_valid & ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    head_d  = pkt_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    skid_d  = pkt_in;
                    state_d = ST_TWO;
                end else if (pop && !push) begin
                    state_d = ST_EMPTY;
                end else if (push && pop) begin
                    head_d = pkt_in;
                end
            end
            ST_TWO: begin
                // ready_q is low here, so only a pop can happen.
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A same-cycle pop was already sampled by EXU; the push is dropped.
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
        end
    end

    assign ready_d = (state_d != ST_TWO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            head_q  <= PKT_RESET;
            skid_q  <= PKT_RESET;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign inst_ready  = ready_q;
    assign out_pc      = head_q.pc;
    assign out_inst    = head_q.inst;
    assign out_imm     = head_q.imm;
    assign out_extop   = head_q.extop;
    assign out_illegal = head_q.illegal;

endmodule
